// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
//   arb_state_e : arbiter FSM state encoding
//   ARB_N       : number of requesters
//   GNT_NONE_N  : active-low grant vector meaning "no owner"
//   CNT_W       : width of the tenure counter
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int          ARB_N      = 4;
  localparam int          CNT_W      = 8;
  localparam logic [3:0]  GNT_NONE_N = 4'b1111;
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

endpackage

// File: rtl/gnt_dec2to4_n.sv
// Active-low 2-to-4 decoder with active-low enable.
//   sel_i   : index of the output to drive low
//   en_n_i  : low enables the decode, high forces all outputs high
//   dec_n_o : active-low one-hot output, 4'b1111 when disabled
module gnt_dec2to4_n
  import arb_pkg::*;
(
  input  logic [1:0] sel_i,
  input  logic       en_n_i,
  output logic [3:0] dec_n_o
);

  always_comb begin
    dec_n_o = GNT_NONE_N;
    if (!en_n_i) begin
      dec_n_o = ~(4'b0001 << sel_i);
    end
  end

endmodule

// File: rtl/rr_arb4_dl.sv
// Four-requester round-robin arbiter driving an active-low grant decoder.
// Each tenure ends on done, on the owner dropping its request, on en_n going
// high, or after HOLD_MAX cycles. One idle cycle always separates grants.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   en_n   : active-low enable; high forces release and blocks new grants
//   req    : active-high requests, bit i = requester i
//   done   : release strobe from the current owner
//   gnt_n  : registered active-low one-hot grant, 4'b1111 = no owner
//   gnt_id : index of the current or most recent owner
//   busy   : high while a grant is held
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no owner; searches req from ptr and grants on next edge
// GRANT | gnt_id owns the resource; cnt tracks tenure length
module rr_arb4_dl
  import arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt_n,
  output logic [1:0] gnt_id,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  arb_state_e       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       gnt_id_q, gnt_id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       gnt_n_q, gnt_n_d;
  logic             busy_q, busy_d;
  logic             rel_c;

  // Rotate so that ptr sits at bit 0, take the lowest set bit, rotate back.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [3:0] rot;
    logic [1:0] win;
    for (int i = 0; i < ARB_N; i++) begin
      rot[i] = r[2'(i + int'(p))];
    end
    win = 2'd0;
    for (int i = ARB_N - 1; i >= 0; i--) begin
      if (rot[i]) win = 2'(i);
    end
    return win + p;
  endfunction

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_id_d = gnt_id_q;
    cnt_d    = cnt_q;
    rel_c    = done | ~req[gnt_id_q] | en_n | (cnt_q == CNT_LAST);
    case (state_q)
      IDLE: begin
        if (!en_n && (|req)) begin
          gnt_id_d = rr_pick(req, ptr_q);
          cnt_d    = '0;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        // All release causes collapse into one exit and one pointer step.
        if (rel_c) begin
          state_d = IDLE;
          ptr_d   = gnt_id_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == GRANT);
  end

  // Decode from next-state values so the grant vector can be registered.
  gnt_dec2to4_n u_dec (
    .sel_i   (gnt_id_d),
    .en_n_i  (~busy_d),
    .dec_n_o (gnt_n_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd0;
      gnt_id_q <= 2'd0;
      cnt_q    <= '0;
      gnt_n_q  <= GNT_NONE_N;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_id_q <= gnt_id_d;
      cnt_q    <= cnt_d;
      gnt_n_q  <= gnt_n_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt_n  = gnt_n_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_rr_arb4_dl.sv
// Self-checking bench for rr_arb4_dl with HOLD_MAX = 4: a behavioural
// reference predicts outputs per cycle into a queue that is popped and
// compared one cycle later, plus directed checks on the scenarios of interest.
module tb_rr_arb4_dl;

  localparam int HOLD = 4;

  typedef struct packed {
    logic [3:0] gnt_n;
    logic [1:0] id;
    logic       busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt_n;
  logic [1:0] gnt_id;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;

  exp_t exp_q[$];

  // reference model state
  logic       m_busy;
  logic [1:0] m_ptr;
  logic [1:0] m_id;
  int         m_cnt;

  rr_arb4_dl #(.HOLD_MAX(HOLD)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_n   (en_n),
    .req    (req),
    .done   (done),
    .gnt_n  (gnt_n),
    .gnt_id (gnt_id),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_ptr  = 2'd0;
    m_id   = 2'd0;
    m_cnt  = 0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    logic [1:0] c;
    logic       found;
    if (!m_busy) begin
      if (!en_n && req != 4'b0000) begin
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          c = m_ptr + 2'(k);
          if (!found && req[c]) begin
            m_id  = c;
            found = 1'b1;
          end
        end
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else begin
      if (done || !req[m_id] || en_n || m_cnt == HOLD - 1) begin
        m_busy = 1'b0;
        m_ptr  = m_id + 2'd1;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic cyc(input string tag);
    exp_t e;
    model_step();
    e.gnt_n = m_busy ? ~(4'b0001 << m_id) : 4'b1111;
    e.id    = m_id;
    e.busy  = m_busy;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, "_gnt_n"}, 32'(gnt_n), 32'(e.gnt_n));
    chk({tag, "_id"}, 32'(gnt_id), 32'(e.id));
    chk({tag, "_busy"}, 32'(busy), 32'(e.busy));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  initial begin
    int low_cnt;
    logic [1:0] rot_seq [5];
    rot_seq[0] = 2'd0; rot_seq[1] = 2'd1; rot_seq[2] = 2'd2;
    rot_seq[3] = 2'd3; rot_seq[4] = 2'd0;

    rst_n = 1'b0; en_n = 1'b1; req = 4'b0000; done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt_n", 32'(gnt_n), 32'h f);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_id", 32'(gnt_id), 32'h0);
    rst_n = 1'b1;

    // reset mid-grant: owner 2 with cnt = 3
    en_n = 1'b0; req = 4'b0100;
    cyc("mg_grant");
    chk("mg_owner", 32'(gnt_id), 32'd2);
    repeat (3) cyc("mg_hold");
    #3 rst_n = 1'b0;
    #1;
    chk("mg_rst_gnt_n", 32'(gnt_n), 32'h f);
    chk("mg_rst_busy", 32'(busy), 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // rotation with done on the second grant cycle
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      done = 1'b0;
      cyc("rot_idle");
      chk("rot_owner", 32'(gnt_id), 32'(rot_seq[t]));
      cyc("rot_c1");
      done = 1'b1;
      cyc("rot_c2");
      chk("rot_gap", 32'(gnt_n), 32'h f);
    end
    done = 1'b0;

    // timeout with a holder that never releases
    req = 4'b0100;
    cyc("to_grant");
    low_cnt = (gnt_n == 4'b1011) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      cyc("to_hold");
      if (gnt_n == 4'b1011) low_cnt++;
      else break;
    end
    chk("to_len", 32'(low_cnt), 32'(HOLD));
    cyc("to_regrant");
    chk("to_regrant_gnt", 32'(gnt_n), 32'h b);
    req = 4'b0000;
    cyc("to_drop");

    // wrap 3 -> 0, then 3
    req = 4'b1000;
    cyc("wr_g3");
    chk("wr_owner3", 32'(gnt_id), 32'd3);
    req = 4'b1001; done = 1'b1;
    cyc("wr_rel3");
    done = 1'b0;
    cyc("wr_g0");
    chk("wr_owner0", 32'(gnt_id), 32'd0);
    done = 1'b1;
    cyc("wr_rel0");
    done = 1'b0;
    cyc("wr_g3b");
    chk("wr_owner3b", 32'(gnt_id), 32'd3);
    done = 1'b1;
    cyc("wr_rel3b");
    done = 1'b0;

    // en_n forces release and blocks grants
    req = 4'b0001;
    cyc("en_g0");
    en_n = 1'b1;
    cyc("en_rel");
    chk("en_rel_gnt", 32'(gnt_n), 32'h f);
    for (int i = 0; i < 5; i++) begin
      cyc("en_block");
      chk("en_block_busy", 32'(busy), 32'h0);
    end
    en_n = 1'b0; req = 4'b0010;

    // done, request drop and timeout on the same edge
    cyc("sim_g1");
    chk("sim_owner1", 32'(gnt_id), 32'd1);
    repeat (3) cyc("sim_hold");
    done = 1'b1; req = 4'b1101;
    cyc("sim_rel");
    done = 1'b0; req = 4'b1111;
    cyc("sim_next");
    chk("sim_owner2", 32'(gnt_id), 32'd2);
    req = 4'b0000;
    cyc("sim_drop");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      req  = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 5) == 0);
      en_n = ($urandom_range(0, 15) == 0);
      cyc("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
